wb_register_bank: RTL
=====================

Name: wb_register_bank

Overview:
- Parametrised successor to the single-register Wishbone wrapper.
- Provides NUM_REGS registers behind one Wishbone slave port: word addressing, byte-lane write enables, a registered single-cycle-latency ack, and an error response for unmapped addresses.
- Each register has a mode: read/write (RW), read-only hardware status (RO), or write-1-to-clear with hardware set (W1C).
- Sits between the Wishbone interconnect and peripheral control/status logic.

Parameters:
- DATA_WIDTH, 32: register and bus data width; must be a multiple of 8.
- NUM_REGS, 8: number of registers; must be at least 1.
- ADDR_WIDTH, 8: width of adr_i (word address).
- BASE_ADDR, 0: word address of register 0.
- REG_MODE, all zeros: 2*NUM_REGS-bit vector; bits [2i+1:2i] set the mode of register i (0=RW, 1=RO, 2=W1C, 3 reserved and treated as RO).
- RESET_VAL, all zeros: NUM_REGS*DATA_WIDTH-bit vector; slice i is the reset value of register i.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cyc_i  in  1  Wishbone cycle valid.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  1=write, 0=read.
- sel_i  in  DATA_WIDTH/8  byte-lane enables; lane k covers dat_i[8k+7:8k].
- adr_i  in  ADDR_WIDTH  word address.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  registered read data.
- ack_o  out  1  registered transfer acknowledge.
- err_o  out  1  registered error acknowledge for an unmapped address.
- reg_q  out  NUM_REGS*DATA_WIDTH  current value of every register, slice i = register i.
- hw_status_i  in  NUM_REGS*DATA_WIDTH  source of RO register values, sampled when read.
- hw_set_i  in  NUM_REGS*DATA_WIDTH  per-bit set pulses for W1C registers; ignored for other modes.

Behaviour:
- Reset (reset=1 on a clk edge): every RW and W1C register loads its RESET_VAL slice; ack_o=0, err_o=0, dat_o=0. Reset overrides any bus request or hw_set_i in the same cycle.
- Decode: off = adr_i - BASE_ADDR, ADDR_WIDTH-bit unsigned with wrap. The access hits when off < NUM_REGS; otherwise it misses.
- Request: req = cyc_i & stb_i & ~ack_o & ~err_o. This gives exactly one response per strobe and forces one idle cycle between back-to-back requests on a held strobe.
- Response timing: a request at edge N produces ack_o (hit) or err_o (miss) high for exactly the one cycle after edge N. Response latency is 1 cycle. ack_o and err_o are never high together.
- Write on a hit, register updated at the same edge as the request:
  - RW: for each lane with sel_i[k]=1, reg[lane k] <= dat_i[lane k]; other lanes are unchanged.
  - W1C: for each enabled lane, bits where dat_i=1 clear.
  - RO: the write is ignored but still acked.
- Write on a miss: no state change; err_o is asserted.
- Read on a hit: dat_o <= hw_status_i slice for RO registers, otherwise the register value. sel_i is ignored on reads (the full word is returned). dat_o holds its value until the next read response.
- Read on a miss: dat_o <= 0 and err_o is asserted.
- W1C hardware set: every cycle, reg <= (reg & ~clear_mask) | hw_set_i slice. If a set and a clear hit the same bit in the same cycle, the set wins.
- reg_q is driven combinationally from the register state, so a write is visible on reg_q one cycle after its request edge. RO slices of reg_q reflect hw_status_i.
- cyc_i dropped with stb_i still high: no request is taken. A response already registered still completes.
- sel_i=0 on a write: no change, but the write is still acked.

Decomposition:
- Shared package wb_register_pkg holds:
  - enum reg_mode_t {REG_RW, REG_RO, REG_W1C}
  - function get_mode(REG_MODE, i)
  - localparam-style helpers for lane count.
- One natural sub-module, wb_reg_cell: a single register with mode, reset value, byte-lane write, W1C clear and hw set. It is instantiated NUM_REGS times in a generate loop.
- Decode, the ack/err flops and the read mux stay in the top module.

Test Plan:
- Reset value: RESET_VAL slice 1 = 0x0000_A5A5; assert reset, read adr 1 -> ack_o high for one cycle, dat_o=0x0000_A5A5, err_o=0.
- Byte-lane RW: reg 0 = 0x1122_3344; write adr 0, dat 0xAABB_CCDD, sel 4'b0101 -> next-cycle read returns 0x11BB_33DD; ack_o pulses exactly once per request.
- W1C with race: hw_set_i pulses bits 0 and 3 on reg 2 (mode W1C) -> reads 0x9. Write 0x9 while hw_set bit 3 pulses in the same cycle -> reads 0x8.
- RO path: hw_status_i slice 3 = 0xDEAD_BEEF, write 0 to adr 3 -> ack, no change; read -> 0xDEAD_BEEF.
- Unmapped: BASE_ADDR=0x10, NUM_REGS=8; access adr 0x18 and adr 0x0F -> err_o one cycle each, ack_o=0, dat_o=0, all registers unchanged.
- Held strobe and reset mid-operation: hold cyc/stb/read for 6 cycles -> ack pattern 1,0,1,0,1,0. Assert reset in the cycle after a write request -> ack_o=0 and registers at RESET_VAL.

Source files
------------

// File: rtl/wb_register_pkg.sv
// Shared types and helpers for the Wishbone register bank.
// Register mode encoding, mode lookup and byte-lane count.
package wb_register_pkg;

  typedef enum logic [1:0] {
    REG_RW  = 2'd0,
    REG_RO  = 2'd1,
    REG_W1C = 2'd2
  } reg_mode_t;

  // Upper bound on register count accepted by get_mode.
  localparam int MAX_REGS = 256;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

  // Code 3 is reserved and behaves as read-only.
  function automatic reg_mode_t get_mode(
    input logic [2*MAX_REGS-1:0] modes,
    input int                    i
  );
    logic [1:0] code;
    code = modes[2*i +: 2];
    unique case (code)
      2'd0:    return REG_RW;
      2'd2:    return REG_W1C;
      default: return REG_RO;
    endcase
  endfunction

endpackage

// File: rtl/wb_register_bank_cell.sv
// One register: byte-lane write, W1C clear with hw set, or RO hold.
// Ports: clk, reset, wr (write hit), sel, wdata, hw_set, q.
module wb_reg_cell
  import wb_register_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter reg_mode_t             MODE       = REG_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   hw_set,
  output logic [DATA_WIDTH-1:0]   q
);

  localparam int LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] clr;

  always_comb begin
    mask = '0;
    for (int k = 0; k < LANES; k++) begin
      mask[8*k +: 8] = {8{sel[k]}};
    end
    clr = wr ? (wdata & mask) : '0;
  end

  // Set is OR-ed after the clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      unique case (MODE)
        REG_RW: begin
          if (wr) q <= (q & ~mask) | (wdata & mask);
        end
        REG_W1C: q <= (q & ~clr) | hw_set;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/wb_register_bank.sv
// Wishbone slave exposing NUM_REGS RW/RO/W1C registers.
// Ports: Wishbone slave (cyc/stb/we/sel/adr/dat/ack/err), reg_q, hw_status_i, hw_set_i.
module wb_register_bank
  import wb_register_pkg::*;
#(
  parameter int                               DATA_WIDTH = 32,
  parameter int                               NUM_REGS   = 8,
  parameter int                               ADDR_WIDTH = 8,
  parameter int                               BASE_ADDR  = 0,
  parameter logic [2*NUM_REGS-1:0]            REG_MODE   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cyc_i,
  input  logic                           stb_i,
  input  logic                           we_i,
  input  logic [DATA_WIDTH/8-1:0]        sel_i,
  input  logic [ADDR_WIDTH-1:0]          adr_i,
  input  logic [DATA_WIDTH-1:0]          dat_i,
  output logic [DATA_WIDTH-1:0]          dat_o,
  output logic                           ack_o,
  output logic                           err_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set_i
);

  logic [ADDR_WIDTH-1:0] off;
  logic                  hit;
  logic                  req;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] view [NUM_REGS];

  assign off = adr_i - ADDR_WIDTH'(BASE_ADDR);
  assign hit = 32'(off) < 32'(NUM_REGS);
  // Blocking on a pending response forces an idle cycle on a held strobe.
  assign req = cyc_i & stb_i & ~ack_o & ~err_o;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_mode_t M =
      get_mode((2*MAX_REGS)'(REG_MODE), i);
    logic [DATA_WIDTH-1:0] q;
    logic                  wr;

    assign wr = req & we_i & hit & (off == ADDR_WIDTH'(i));

    wb_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODE       (M),
      .RESET_VAL  (RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr),
      .sel    (sel_i),
      .wdata  (dat_i),
      .hw_set (hw_set_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .q      (q)
    );

    if (M == REG_RO) begin : g_ro
      assign view[i] = hw_status_i[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_st
      assign view[i] = q;
    end

    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = view[i];
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (off == ADDR_WIDTH'(i)) rdata = view[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req & hit;
      err_o <= req & ~hit;
      if (req & ~we_i) dat_o <= hit ? rdata : '0;
    end
  end

endmodule
